operand_stage: RTL and testbench

// Decode/operand-fetch stage directly upstream of the register file. Extracts rs1/rs2/rd from
// the fetched instruction, drives the register file read addresses and captures operands.

---
 rtl/operand_stage_if.sv | 55 +++++
 rtl/operand_stage.sv | 145 ++++++++++++++
 tb/tb_operand_stage.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_stage_if.sv
// operand_stage_if: fetch-side handshake, register file read/observe ports
// and the execute-side output register, bundled for the operand stage.
interface operand_stage_if #(
    parameter int XLEN = 32
);
    // Fetch side
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    // Register file read ports
    logic [4:0]      rf_raddr0;
    logic [4:0]      rf_raddr1;
    logic [XLEN-1:0] rf_rdata0;
    logic [XLEN-1:0] rf_rdata1;

    // Register file write port, observed for bypass and scoreboard release
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    // Kill of the instruction held in the output register
    logic            flush;

    // Execute side
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_rs1_val;
    logic [XLEN-1:0] out_rs2_val;
    logic [4:0]      out_rd;
    logic            out_rd_we;

    // The operand stage itself
    modport slave (
        input  in_valid, in_instr, in_pc,
        input  rf_rdata0, rf_rdata1,
        input  wb_valid, wb_rd, wb_data,
        input  flush, out_ready,
        output in_ready, rf_raddr0, rf_raddr1,
        output out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val, out_rd, out_rd_we
    );

    // The surrounding pipeline (fetch, register file, execute)
    modport master (
        output in_valid, in_instr, in_pc,
        output rf_rdata0, rf_rdata1,
        output wb_valid, wb_rd, wb_data,
        output flush, out_ready,
        input  in_ready, rf_raddr0, rf_raddr1,
        input  out_valid, out_pc, out_instr, out_rs1_val, out_rs2_val, out_rd, out_rd_we
    );
endinterface

// File: rtl/operand_stage.sv
// operand_stage: RV32I decode/operand fetch. Reads the register file,
// bypasses from writeback, stalls RAW/WAW hazards through a 32-entry busy
// scoreboard and hands the result to execute through a valid/ready register.
module operand_stage #(
    parameter int XLEN      = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    operand_stage_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            rd_we;
    logic            rs1_byp;
    logic            rs2_byp;
    logic            rd_wb_hit;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;
    logic            slot_free;
    logic            in_ready;
    logic            issue;

    logic [31:0]     busy;
    logic [31:0]     busy_nxt;

    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [31:0]     out_instr_q;
    logic [XLEN-1:0] out_rs1_q;
    logic [XLEN-1:0] out_rs2_q;
    logic [4:0]      out_rd_q;
    logic            out_rd_we_q;

    assign opcode = bus.in_instr[6:0];
    assign rd     = bus.in_instr[11:7];
    assign rs1    = bus.in_instr[19:15];
    assign rs2    = bus.in_instr[24:20];

    // Decode which sources the instruction reads and whether it writes rd.
    always_comb begin
        use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        use_rs2 = (opcode == OP_BRANCH) || (opcode == OP_STORE) || (opcode == OP_OP);
        rd_we   = !(opcode == OP_BRANCH || opcode == OP_STORE) && (rd != 5'd0);
    end

    // Select operand values: x0 reads zero, a same-cycle writeback wins over the array.
    always_comb begin
        rs1_byp   = BYPASS_EN && bus.wb_valid && (bus.wb_rd == rs1);
        rs2_byp   = BYPASS_EN && bus.wb_valid && (bus.wb_rd == rs2);
        rd_wb_hit = bus.wb_valid && (bus.wb_rd == rd);

        if (rs1 == 5'd0)  rs1_val = '0;
        else if (rs1_byp) rs1_val = bus.wb_data;
        else              rs1_val = bus.rf_rdata0;

        if (rs2 == 5'd0)  rs2_val = '0;
        else if (rs2_byp) rs2_val = bus.wb_data;
        else              rs2_val = bus.rf_rdata1;
    end

    // Hazard detection: RAW on used sources not covered by bypass, WAW on rd.
    always_comb begin
        hazard = (use_rs1 && (rs1 != 5'd0) && busy[rs1] && !rs1_byp)
              || (use_rs2 && (rs2 != 5'd0) && busy[rs2] && !rs2_byp)
              || (rd_we && busy[rd] && !rd_wb_hit);
    end

    assign slot_free = !out_valid_q || bus.out_ready;
    assign in_ready  = slot_free && !hazard && !bus.flush;
    assign issue     = bus.in_valid && in_ready;

    // Scoreboard update: releases first, then a new writer's set so that set wins.
    always_comb begin
        // NOTE: start from the held value so every path assigns busy_nxt and no latch is inferred.
        busy_nxt = busy;
        if (bus.wb_valid) begin
            busy_nxt[bus.wb_rd] = 1'b0;
        end
        if (bus.flush && out_valid_q && out_rd_we_q) begin
            busy_nxt[out_rd_q] = 1'b0;
        end
        if (issue && rd_we) begin
            busy_nxt[rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the busy array is reset like any control flop; a stale bit would stall forever.
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Output pipeline register: load on issue, drain on consume or flush, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_rs1_q   <= '0;
            out_rs2_q   <= '0;
            out_rd_q    <= '0;
            out_rd_we_q <= 1'b0;
        end else if (issue) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= bus.in_pc;
            out_instr_q <= bus.in_instr;
            out_rs1_q   <= rs1_val;
            out_rs2_q   <= rs2_val;
            out_rd_q    <= rd;
            out_rd_we_q <= rd_we;
        end else if (bus.out_ready || bus.flush) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.rf_raddr0   = rs1;
    assign bus.rf_raddr1   = rs2;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_instr   = out_instr_q;
    assign bus.out_rs1_val = out_rs1_q;
    assign bus.out_rs2_val = out_rs2_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_rd_we   = out_rd_we_q;
endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: vector table, directed corner sequences and a randomized
// run against a scoreboard model for operand_stage (bypass on and off).
module tb_operand_stage;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    operand_stage_if #(.XLEN(32)) bif ();
    operand_stage_if #(.XLEN(32)) nbif ();

    operand_stage #(.XLEN(32), .BYPASS_EN(1'b1)) dut    (.clk(clk), .rst_n(rst_n), .bus(bif));
    operand_stage #(.XLEN(32), .BYPASS_EN(1'b0)) dut_nb (.clk(clk), .rst_n(rst_n), .bus(nbif));

    // Register file model: combinational read, write on the clock edge.
    assign bif.rf_rdata0  = rf[bif.rf_raddr0];
    assign bif.rf_rdata1  = rf[bif.rf_raddr1];
    assign nbif.rf_rdata0 = rf[nbif.rf_raddr0];
    assign nbif.rf_rdata1 = rf[nbif.rf_raddr1];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h1000 + i;
            rf[0] <= 32'hdead_beef;
        end else begin
            if (bif.wb_valid && bif.wb_rd != 5'd0)   rf[bif.wb_rd]  <= bif.wb_data;
            if (nbif.wb_valid && nbif.wb_rd != 5'd0) rf[nbif.wb_rd] <= nbif.wb_data;
        end
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [4:0]  rd;
        logic        rd_we;
    } vec_t;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, op};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        bif.in_valid  = 1'b0; bif.in_instr = '0; bif.in_pc = '0;
        bif.wb_valid  = 1'b0; bif.wb_rd = '0;   bif.wb_data = '0;
        bif.flush     = 1'b0; bif.out_ready = 1'b1;
        nbif.in_valid = 1'b0; nbif.in_instr = '0; nbif.in_pc = '0;
        nbif.wb_valid = 1'b0; nbif.wb_rd = '0;   nbif.wb_data = '0;
        nbif.flush    = 1'b0; nbif.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic ordy, input logic fl, input logic wbv,
                         input logic [4:0] wbr, input logic [31:0] wbd);
        bif.in_valid = v;   bif.in_instr = instr; bif.in_pc = pc;
        bif.out_ready = ordy; bif.flush = fl;
        bif.wb_valid = wbv; bif.wb_rd = wbr; bif.wb_data = wbd;
    endtask

    vec_t vecs[7];
    logic [6:0] ops[8];
    int unsigned pend[$];

    initial begin
        vecs[0] = '{enc(OP_OP,     5'd1,  5'd2,  5'd3),  32'h100, 32'h1002, 32'h1003, 5'd1,  1'b1};
        vecs[1] = '{enc(OP_STORE,  5'd4,  5'd5,  5'd6),  32'h104, 32'h1005, 32'h1006, 5'd4,  1'b0};
        vecs[2] = '{enc(OP_BRANCH, 5'd0,  5'd0,  5'd7),  32'h108, 32'h0,    32'h1007, 5'd0,  1'b0};
        vecs[3] = '{enc(OP_LUI,    5'd8,  5'd9,  5'd10), 32'h10c, 32'h1009, 32'h100a, 5'd8,  1'b1};
        vecs[4] = '{enc(OP_IMM,    5'd0,  5'd11, 5'd12), 32'h110, 32'h100b, 32'h100c, 5'd0,  1'b0};
        vecs[5] = '{enc(OP_JAL,    5'd13, 5'd1,  5'd2),  32'h114, 32'h1001, 32'h1002, 5'd13, 1'b1};
        vecs[6] = '{enc(OP_LOAD,   5'd14, 5'd15, 5'd1),  32'h118, 32'h100f, 32'h1001, 5'd14, 1'b1};
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_BRANCH, OP_STORE, OP_OP, OP_IMM, OP_LOAD};

        // Reset state
        do_reset();
        #1;
        check("rst out_valid", bif.out_valid, 0);
        check("rst in_ready", bif.in_ready, 1);
        check("rst busy", dut.busy, 0);
        check("rst out_pc", bif.out_pc, 0);
        check("rst out_rs1", bif.out_rs1_val, 0);
        check("rst nb busy", dut_nb.busy, 0);

        // Independent instructions from a table
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
            #1;
            check("vec in_ready", bif.in_ready, 1);
            check("vec raddr0", bif.rf_raddr0, 64'(vecs[i].instr[19:15]));
            check("vec raddr1", bif.rf_raddr1, 64'(vecs[i].instr[24:20]));
            @(posedge clk); #1;
            check("vec out_valid", bif.out_valid, 1);
            check("vec out_pc", bif.out_pc, vecs[i].pc);
            check("vec out_instr", bif.out_instr, vecs[i].instr);
            check("vec rs1_val", bif.out_rs1_val, vecs[i].rs1_val);
            check("vec rs2_val", bif.out_rs2_val, vecs[i].rs2_val);
            check("vec out_rd", bif.out_rd, 64'(vecs[i].rd));
            check("vec out_rd_we", bif.out_rd_we, 64'(vecs[i].rd_we));
        end
        check("vec busy", dut.busy, 32'h0000_6102);

        // RAW stall released by same-cycle writeback bypass
        do_reset();
        drive(1'b1, 32'h0050_0293, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #1; check("raw addi in_ready", bif.in_ready, 1);
        @(posedge clk); #1;
        check("raw addi busy", dut.busy, 32'h20);
        check("raw addi rd_we", bif.out_rd_we, 1);
        @(negedge clk);
        drive(1'b1, 32'h0052_8333, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #1; check("raw add stalled", bif.in_ready, 0);
        @(posedge clk); #1;
        check("raw drained", bif.out_valid, 0);
        @(negedge clk);
        drive(1'b1, 32'h0052_8333, 32'h204, 1'b1, 1'b0, 1'b1, 5'd5, 32'd5);
        #1; check("raw wb in_ready", bif.in_ready, 1);
        @(posedge clk); #1;
        check("raw add pc", bif.out_pc, 32'h204);
        check("raw add rs1", bif.out_rs1_val, 5);
        check("raw add rs2", bif.out_rs2_val, 5);
        check("raw busy", dut.busy, 32'h40);

        // Reset while stalled on x6 drops the pending state
        @(negedge clk);
        drive(1'b1, enc(OP_OP, 5'd7, 5'd6, 5'd0), 32'h208, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #1; check("midrst stalled", bif.in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("midrst busy", dut.busy, 0);
        check("midrst out_valid", bif.out_valid, 0);
        do_reset();

        // No bypass: issue one cycle after the writeback cycle, operands from the array
        nbif.in_valid = 1'b1; nbif.in_instr = 32'h0050_0293; nbif.in_pc = 32'h400;
        #1; check("nb addi in_ready", nbif.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        nbif.in_instr = 32'h0052_8333; nbif.in_pc = 32'h404;
        #1; check("nb add stalled", nbif.in_ready, 0);
        @(negedge clk);
        nbif.wb_valid = 1'b1; nbif.wb_rd = 5'd5; nbif.wb_data = 32'd5;
        #1; check("nb wb cycle stalled", nbif.in_ready, 0);
        @(posedge clk); #1;
        check("nb no issue yet", nbif.out_valid, 0);
        @(negedge clk);
        nbif.wb_valid = 1'b0;
        #1; check("nb in_ready after", nbif.in_ready, 1);
        @(posedge clk); #1;
        check("nb add pc", nbif.out_pc, 32'h404);
        check("nb add rs1", nbif.out_rs1_val, 5);
        check("nb add rs2", nbif.out_rs2_val, 5);
        check("nb busy", dut_nb.busy, 32'h40);
        @(negedge clk);
        idle();

        // Writes to x0 set nothing and read back zero
        do_reset();
        drive(1'b1, 32'h0010_0013, 32'h500, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #1; check("x0 addi in_ready", bif.in_ready, 1);
        @(posedge clk); #1;
        check("x0 addi rd_we", bif.out_rd_we, 0);
        check("x0 addi busy", dut.busy, 0);
        @(negedge clk);
        drive(1'b1, 32'h0000_0333, 32'h504, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #1; check("x0 add in_ready", bif.in_ready, 1);
        @(posedge clk); #1;
        check("x0 add rs1", bif.out_rs1_val, 0);
        check("x0 add rs2", bif.out_rs2_val, 0);
        check("x0 add rd_we", bif.out_rd_we, 1);
        check("x0 add busy", dut.busy, 32'h40);

        // Backpressure holds the output, release issues in the same cycle
        do_reset();
        drive(1'b1, enc(OP_OP, 5'd9, 5'd1, 5'd2), 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        #1; check("bp first in_ready", bif.in_ready, 1);
        @(posedge clk); #1;
        check("bp first valid", bif.out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, enc(OP_OP, 5'd10, 5'd3, 5'd4), 32'h304, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            #1; check("bp in_ready low", bif.in_ready, 0);
            @(posedge clk); #1;
            check("bp hold valid", bif.out_valid, 1);
            check("bp hold pc", bif.out_pc, 32'h300);
            check("bp hold rs1", bif.out_rs1_val, 32'h1001);
            check("bp hold rd", bif.out_rd, 9);
        end
        @(negedge clk);
        drive(1'b1, enc(OP_OP, 5'd10, 5'd3, 5'd4), 32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #1; check("bp release in_ready", bif.in_ready, 1);
        @(posedge clk); #1;
        check("bp next pc", bif.out_pc, 32'h304);
        check("bp next rd", bif.out_rd, 10);

        // Flush kills the held writer and releases its busy bit
        do_reset();
        drive(1'b1, 32'h0010_0393, 32'h600, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        check("fl busy set", dut.busy, 32'h80);
        @(negedge clk);
        drive(1'b1, enc(OP_OP, 5'd9, 5'd1, 5'd2), 32'h604, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        #1; check("fl in_ready", bif.in_ready, 0);
        @(posedge clk); #1;
        check("fl out_valid", bif.out_valid, 0);
        check("fl busy clear", dut.busy, 0);
        @(negedge clk);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77);
        @(posedge clk); #1;
        check("fl late wb busy", dut.busy, 0);
        check("fl late wb valid", bif.out_valid, 0);

        // Randomized run against the scoreboard model
        do_reset();
        begin
            logic [31:0] m_busy, nb;
            logic        m_ov, m_we;
            logic [31:0] m_pc, m_instr, m_r1, m_r2;
            logic [4:0]  m_rd;
            m_busy = '0; m_ov = 1'b0; m_we = 1'b0; m_rd = '0;
            m_pc = '0; m_instr = '0; m_r1 = '0; m_r2 = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic [6:0]  op;
                logic [4:0]  r1, r2, rd, wbr;
                logic [31:0] instr, pc, wbd, v1, v2;
                logic        iv, ordy, fl, wbv, u1, u2, we, byp1, byp2, haz, rdy;
                @(negedge clk);
                op    = ops[$urandom_range(0, 7)];
                rd    = 5'($urandom_range(0, 7));
                r1    = 5'($urandom_range(0, 7));
                r2    = 5'($urandom_range(0, 7));
                instr = enc(op, rd, r1, r2);
                pc    = 32'($urandom) & ~32'h3;
                iv    = ($urandom_range(0, 9) < 8);
                ordy  = ($urandom_range(0, 9) < 7);
                fl    = ($urandom_range(0, 11) == 0);
                wbv   = 1'b0; wbr = '0; wbd = $urandom;
                if ($urandom_range(0, 9) < 4) begin
                    pend.delete();
                    for (int r = 1; r < 8; r++) if (m_busy[r]) pend.push_back(r);
                    if (pend.size() > 0 && $urandom_range(0, 3) != 0)
                        wbr = 5'(pend[$urandom_range(0, pend.size() - 1)]);
                    else
                        wbr = 5'($urandom_range(0, 7));
                    wbv = 1'b1;
                end
                drive(iv, instr, pc, ordy, fl, wbv, wbr, wbd);
                #1;
                u1   = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
                u2   = (op == OP_BRANCH || op == OP_STORE || op == OP_OP);
                we   = !(op == OP_BRANCH || op == OP_STORE) && rd != 0;
                byp1 = wbv && wbr == r1;
                byp2 = wbv && wbr == r2;
                haz  = (u1 && r1 != 0 && m_busy[r1] && !byp1)
                    || (u2 && r2 != 0 && m_busy[r2] && !byp2)
                    || (we && m_busy[rd] && !(wbv && wbr == rd));
                rdy  = (!m_ov || ordy) && !haz && !fl;
                check("rnd in_ready", bif.in_ready, rdy);
                v1 = (r1 == 0) ? 32'd0 : (byp1 ? wbd : rf[r1]);
                v2 = (r2 == 0) ? 32'd0 : (byp2 ? wbd : rf[r2]);
                nb = m_busy;
                if (wbv) nb[wbr] = 1'b0;
                if (fl && m_ov && m_we) nb[m_rd] = 1'b0;
                if (iv && rdy && we) nb[rd] = 1'b1;
                nb[0] = 1'b0;
                if (iv && rdy) begin
                    m_ov = 1'b1; m_pc = pc; m_instr = instr;
                    m_r1 = v1; m_r2 = v2; m_rd = rd; m_we = we;
                end else if (ordy || fl) begin
                    m_ov = 1'b0;
                end
                m_busy = nb;
                @(posedge clk); #1;
                check("rnd out_valid", bif.out_valid, m_ov);
                check("rnd out_pc", bif.out_pc, m_pc);
                check("rnd out_instr", bif.out_instr, m_instr);
                check("rnd rs1_val", bif.out_rs1_val, m_r1);
                check("rnd rs2_val", bif.out_rs2_val, m_r2);
                check("rnd out_rd", bif.out_rd, 64'(m_rd));
                check("rnd out_rd_we", bif.out_rd_we, 64'(m_we));
                check("rnd busy", dut.busy, m_busy);
            end
        end

        @(negedge clk);
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
